// File: rtl/button_pkg.sv
// Shared types and constants for the button bank renderer: FSM state
// encoding, sprite style indices and the default transparent colour.
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    HOVER    = 3'd1,
    PRESSED  = 3'd2,
    FLASH    = 3'd3,
    DISABLED = 3'd4
  } btn_state_t;

  localparam logic [1:0] STYLE_NORMAL   = 2'd0;
  localparam logic [1:0] STYLE_HOVER    = 2'd1;
  localparam logic [1:0] STYLE_PRESSED  = 2'd2;
  localparam logic [1:0] STYLE_DISABLED = 2'd3;

  localparam logic [23:0] KEY_COLOR_DEFAULT = 24'hFF00FF;

  // FLASH blinks between hover and pressed art, keyed on the flash counter parity.
  function automatic logic [1:0] style_of(btn_state_t s, logic cnt_odd);
    case (s)
      IDLE:    return STYLE_NORMAL;
      HOVER:   return STYLE_HOVER;
      PRESSED: return STYLE_PRESSED;
      FLASH:   return cnt_odd ? STYLE_PRESSED : STYLE_HOVER;
      default: return STYLE_DISABLED;
    endcase
  endfunction

endpackage

// File: rtl/draw_button_bank_if.sv
// Scanner/compositor-facing bundle of the button bank, plus per-button
// FSM state exported for observation.
interface draw_button_bank_if #(
  parameter int NUM_BUTTONS = 4
) ();
  import button_pkg::*;

  localparam int SEL_W = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  // pix_valid qualifies btn_sel/x_pos/y_pos in the same cycle; there is no
  // ready: the bank accepts one pixel every cycle. out_valid qualifies
  // out_data/out_opaque, which read as 0 whenever out_valid is low.
  logic                   frame_start;
  logic                   pix_valid;
  logic [SEL_W-1:0]       btn_sel;
  logic [7:0]             x_pos;
  logic [5:0]             y_pos;
  logic [NUM_BUTTONS-1:0] hover;
  logic [NUM_BUTTONS-1:0] press;
  logic [NUM_BUTTONS-1:0] enable;
  logic [23:0]            out_data;
  logic                   out_valid;
  logic                   out_opaque;
  logic [NUM_BUTTONS-1:0] clicked;
  btn_state_t [NUM_BUTTONS-1:0] dbg_state;

  modport master (
    output frame_start, pix_valid, btn_sel, x_pos, y_pos, hover, press, enable,
    input  out_data, out_valid, out_opaque, clicked, dbg_state
  );

  modport slave (
    input  frame_start, pix_valid, btn_sel, x_pos, y_pos, hover, press, enable,
    output out_data, out_valid, out_opaque, clicked, dbg_state
  );

endinterface

// File: rtl/button_fsm.sv
// Interaction FSM for one button: state, click-flash counter, one-cycle
// click pulse and the per-frame style latch used for rendering.
module button_fsm
  import button_pkg::*;
#(
  parameter int FLASH_FRAMES = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_start,
  input  logic       hover,
  input  logic       press,
  input  logic       enable,
  output logic [1:0] style,
  output logic       clicked,
  output btn_state_t state
);

  localparam int CNT_W = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [CNT_W-1:0] FLASH_LOAD = CNT_W'(FLASH_FRAMES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      clicked <= 1'b0;
      style   <= STYLE_NORMAL;
    end else begin
      clicked <= 1'b0;
      // Latched from the pre-transition state so a frame never shows half an update.
      if (frame_start) style <= style_of(state, cnt[0]);
      if (!enable) begin
        state <= DISABLED;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (hover && press) state <= PRESSED;
            else if (hover)     state <= HOVER;
          end
          HOVER: begin
            if (!hover)     state <= IDLE;
            else if (press) state <= PRESSED;
          end
          PRESSED: begin
            if (!press) begin
              if (hover) begin
                state   <= FLASH;
                cnt     <= FLASH_LOAD;
                clicked <= 1'b1;
              end else begin
                state <= IDLE;
              end
            end
          end
          FLASH: begin
            if (frame_start) begin
              if (cnt == '0) state <= hover ? HOVER : IDLE;
              else           cnt   <= cnt - 1'b1;
            end
          end
          DISABLED: state <= IDLE;
          default:  state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: rtl/buttons_mem.sv
// Sprite ROM holding four stacked button styles, read through a LAT-deep
// register pipeline. Contents are a procedural pattern with keyed pixels.
module buttons_mem #(
  parameter int          ADDR_W    = 15,
  parameter int          LAT       = 2,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [23:0]       q
);

  logic [23:0] pipe [LAT];

  // Every sixteenth word is transparent so the key path gets exercised in art.
  function automatic logic [23:0] word_at(logic [ADDR_W-1:0] a);
    if (a[3:0] == 4'hF) return KEY_COLOR;
    return (24'(a) << 9) | 24'h000055;
  endfunction

  always_ff @(posedge clk) begin
    pipe[0] <= word_at(addr);
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end

  assign q = pipe[LAT-1];

endmodule

// File: rtl/draw_button_bank.sv
// Bank of button FSMs sharing one sprite ROM; turns button-local pixel
// coordinates into a latency-aligned RGB pixel with an opacity flag.
module draw_button_bank
  import button_pkg::*;
#(
  parameter int          NUM_BUTTONS  = 4,
  parameter int          BTN_W        = 155,
  parameter int          BTN_H        = 38,
  parameter int          ADDR_W       = 15,
  parameter int          ROM_LAT      = 2,
  parameter int          FLASH_FRAMES = 6,
  parameter logic [23:0] KEY_COLOR    = KEY_COLOR_DEFAULT
) (
  input  logic              vga_clk,
  input  logic              reset,
  draw_button_bank_if.slave bus
);

  localparam int SEL_W   = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;
  localparam int NUM_SEL = 2 ** SEL_W;
  localparam logic [ADDR_W-1:0] STYLE_STRIDE = ADDR_W'(BTN_W * BTN_H);
  localparam logic [ADDR_W-1:0] ROW_STRIDE   = ADDR_W'(BTN_W);

  logic [1:0]                   style_tab [NUM_SEL];
  logic [NUM_BUTTONS-1:0]       clicked_w;
  btn_state_t [NUM_BUTTONS-1:0] state_w;

  // Unused select codes read as style 0 so the lookup never leaves the table.
  for (genvar i = 0; i < NUM_SEL; i++) begin : g_btn
    if (i < NUM_BUTTONS) begin : g_fsm
      button_fsm #(.FLASH_FRAMES(FLASH_FRAMES)) u_fsm (
        .clk         (vga_clk),
        .reset       (reset),
        .frame_start (bus.frame_start),
        .hover       (bus.hover[i]),
        .press       (bus.press[i]),
        .enable      (bus.enable[i]),
        .style       (style_tab[i]),
        .clicked     (clicked_w[i]),
        .state       (state_w[i])
      );
    end else begin : g_pad
      assign style_tab[i] = STYLE_NORMAL;
    end
  end

  assign bus.clicked   = clicked_w;
  assign bus.dbg_state = state_w;

  logic              in_range;
  logic [1:0]        sel_style;
  logic [ADDR_W-1:0] addr_calc;

  always_comb begin
    in_range  = (int'(bus.btn_sel) < NUM_BUTTONS) &&
                (int'(bus.x_pos) < BTN_W) &&
                (int'(bus.y_pos) < BTN_H);
    sel_style = style_tab[bus.btn_sel];
    addr_calc = '0;
    if (in_range)
      addr_calc = ADDR_W'(sel_style) * STYLE_STRIDE +
                  ADDR_W'(bus.y_pos) * ROW_STRIDE + ADDR_W'(bus.x_pos);
  end

  logic [ADDR_W-1:0] addr_q;
  logic [ROM_LAT:0]  vld_sr;
  logic [ROM_LAT:0]  inr_sr;
  logic [23:0]       rom_q;
  logic [23:0]       data_r;
  logic              valid_r;
  logic              opaque_r;

  buttons_mem #(
    .ADDR_W    (ADDR_W),
    .LAT       (ROM_LAT),
    .KEY_COLOR (KEY_COLOR)
  ) u_mem (
    .clk  (vga_clk),
    .addr (addr_q),
    .q    (rom_q)
  );

  // Bit 0 of each flag shift register is the address stage; bit ROM_LAT lines up with rom_q.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      addr_q   <= '0;
      vld_sr   <= '0;
      inr_sr   <= '0;
      valid_r  <= 1'b0;
      data_r   <= '0;
      opaque_r <= 1'b0;
    end else begin
      addr_q  <= addr_calc;
      vld_sr  <= {vld_sr[ROM_LAT-1:0], bus.pix_valid};
      inr_sr  <= {inr_sr[ROM_LAT-1:0], in_range};
      valid_r <= vld_sr[ROM_LAT];
      if (vld_sr[ROM_LAT] && inr_sr[ROM_LAT]) begin
        data_r   <= rom_q;
        opaque_r <= (rom_q != KEY_COLOR);
      end else begin
        data_r   <= '0;
        opaque_r <= 1'b0;
      end
    end
  end

  assign bus.out_data   = data_r;
  assign bus.out_valid  = valid_r;
  assign bus.out_opaque = opaque_r;

endmodule

// File: tb/tb_draw_button_bank.sv
// Bench for draw_button_bank: directed scenarios then random traffic, all
// checked cycle by cycle against a behavioural model of the button bank.
module tb_draw_button_bank;
  import button_pkg::*;

  localparam int NB     = 3;
  localparam int BW     = 155;
  localparam int BH     = 38;
  localparam int FRAMES = 6;
  localparam int PIPE   = 4;
  localparam logic [23:0] KEY = 24'hFF00FF;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  draw_button_bank_if #(.NUM_BUTTONS(NB)) bus ();

  draw_button_bank #(.NUM_BUTTONS(NB)) dut (
    .vga_clk (clk),
    .reset   (rst),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [25:0] exp_q[$];
  btn_state_t  m_state [NB];
  int          m_age   [NB];
  int          m_style [NB];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model
  function automatic logic [23:0] rom_word(int a);
    if (a % 16 == 15) return KEY;
    return 24'(a * 512 + 85);
  endfunction

  function automatic logic [25:0] pixel_expect();
    int s, x, y, a;
    logic [23:0] w;
    if (!bus.pix_valid) return '0;
    s = int'(bus.btn_sel);
    x = int'(bus.x_pos);
    y = int'(bus.y_pos);
    if (s >= NB || x >= BW || y >= BH) return {1'b1, 1'b0, 24'h0};
    a = m_style[s] * BW * BH + y * BW + x;
    w = rom_word(a);
    return {1'b1, (w != KEY), w};
  endfunction

  function automatic int shown_style(int i);
    if (m_state[i] == IDLE)    return 0;
    if (m_state[i] == HOVER)   return 1;
    if (m_state[i] == PRESSED) return 2;
    if (m_state[i] == FLASH)   return (m_age[i] % 2 == 0) ? 2 : 1;
    return 3;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_state[i] = IDLE;
      m_age[i]   = 0;
      m_style[i] = 0;
    end
  endtask

  task automatic model_update(output logic [NB-1:0] exp_click);
    logic h, p, en, fs;
    fs = bus.frame_start;
    for (int i = 0; i < NB; i++) begin
      h  = bus.hover[i];
      p  = bus.press[i];
      en = bus.enable[i];
      exp_click[i] = en && (m_state[i] == PRESSED) && !p && h;
      if (fs) m_style[i] = shown_style(i);
      if (!en) begin
        m_state[i] = DISABLED;
        m_age[i]   = 0;
      end else if (m_state[i] == DISABLED) begin
        m_state[i] = IDLE;
      end else if (m_state[i] == IDLE) begin
        if (h) m_state[i] = p ? PRESSED : HOVER;
      end else if (m_state[i] == HOVER) begin
        if (!h)     m_state[i] = IDLE;
        else if (p) m_state[i] = PRESSED;
      end else if (m_state[i] == PRESSED) begin
        if (!p) begin
          m_state[i] = h ? FLASH : IDLE;
          m_age[i]   = 0;
        end
      end else if (fs) begin
        if (m_age[i] == FRAMES - 1) m_state[i] = h ? HOVER : IDLE;
        else                        m_age[i]++;
      end
    end
  endtask

  // one clock: predict, advance, compare
  task automatic step(input string tag);
    logic [25:0]       e;
    logic [NB-1:0]     ec;
    logic [3*NB-1:0]   es;
    if (rst) begin
      @(posedge clk); #1;
      model_reset();
      exp_q.delete();
      for (int k = 0; k < PIPE - 1; k++) exp_q.push_back('0);
      ec = '0;
      e  = '0;
    end else begin
      exp_q.push_back(pixel_expect());
      model_update(ec);
      @(posedge clk); #1;
      e = exp_q.pop_front();
    end
    for (int i = 0; i < NB; i++) es[i*3 +: 3] = m_state[i];
    check({tag, ":pix"},     32'({bus.out_valid, bus.out_opaque, bus.out_data}), 32'(e));
    check({tag, ":clicked"}, 32'(bus.clicked), 32'(ec));
    check({tag, ":state"},   32'(bus.dbg_state), 32'(es));
  endtask

  // driver tasks
  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  task automatic pixel(input int sel, input int x, input int y, input string tag);
    bus.pix_valid = 1'b1;
    bus.btn_sel   = 2'(sel);
    bus.x_pos     = 8'(x);
    bus.y_pos     = 6'(y);
    step(tag);
    bus.pix_valid = 1'b0;
  endtask

  task automatic frame(input string tag);
    bus.frame_start = 1'b1;
    step(tag);
    bus.frame_start = 1'b0;
  endtask

  task automatic rand_cycle(input int cyc);
    for (int i = 0; i < NB; i++) begin
      if ($urandom_range(0, 9) == 0) bus.hover[i] = ~bus.hover[i];
      if ($urandom_range(0, 7) == 0) bus.press[i] = ~bus.press[i];
      if (bus.enable[i]) begin
        if ($urandom_range(0, 59) == 0) bus.enable[i] = 1'b0;
      end else if ($urandom_range(0, 5) == 0) begin
        bus.enable[i] = 1'b1;
      end
    end
    bus.frame_start = (cyc % 12 == 0);
    bus.pix_valid   = ($urandom_range(0, 3) != 0);
    bus.btn_sel     = 2'($urandom_range(0, 3));
    bus.x_pos       = 8'($urandom_range(0, 159));
    bus.y_pos       = 6'($urandom_range(0, 41));
    step("rand");
  endtask

  initial begin
    rst             = 1'b1;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    bus.btn_sel     = '0;
    bus.x_pos       = '0;
    bus.y_pos       = '0;
    bus.hover       = '0;
    bus.press       = '0;
    bus.enable      = '1;
    model_reset();
    idle(2, "reset");
    rst = 1'b0;

    // first pixel after reset: ROM word 0
    pixel(0, 0, 0, "first_pix");
    idle(5, "first_pix");

    // hovered button 1 draws from style 1
    bus.hover[1] = 1'b1;
    idle(2, "hover1");
    pixel(1, 10, 2, "hover1_pre_frame");
    frame("hover1");
    pixel(1, 10, 2, "hover1_addr");
    idle(4, "hover1");

    // click on button 2, then the flash sequence
    bus.hover[2] = 1'b1;
    idle(2, "click2");
    bus.press[2] = 1'b1;
    idle(2, "click2");
    bus.press[2] = 1'b0;
    idle(3, "click2");
    for (int f = 0; f < 8; f++) begin
      frame("flash2");
      pixel(2, f, 1, "flash2_pix");
      idle(3, "flash2");
    end

    // release after hover drops: no click
    bus.hover[0] = 1'b1;
    idle(1, "noclick0");
    bus.press[0] = 1'b1;
    idle(2, "noclick0");
    bus.hover[0] = 1'b0;
    idle(2, "noclick0");
    bus.press[0] = 1'b0;
    idle(2, "noclick0");

    // disable while pressed
    bus.hover[0] = 1'b1;
    bus.press[0] = 1'b1;
    idle(2, "dis0");
    bus.enable[0] = 1'b0;
    idle(1, "dis0");
    bus.press[0] = 1'b0;
    bus.hover[0] = 1'b0;
    idle(2, "dis0");
    frame("dis0");
    pixel(0, 0, 0, "dis0_base");
    idle(4, "dis0");
    bus.enable[0] = 1'b1;
    idle(2, "dis0");

    // out-of-range and keyed pixels, back to back
    pixel(0, 155, 0, "oor_x");
    pixel(3, 0, 0, "oor_sel");
    pixel(0, 0, 38, "oor_y");
    pixel(0, 9, 0, "key");
    pixel(0, 154, 37, "corner");
    idle(5, "edges");

    // reset with pixels in flight
    bus.pix_valid = 1'b1;
    bus.btn_sel   = 2'd1;
    bus.x_pos     = 8'd3;
    bus.y_pos     = 6'd3;
    idle(3, "inflight");
    rst = 1'b1;
    step("inflight_rst");
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    idle(6, "after_rst");

    for (int c = 0; c < 1500; c++) rand_cycle(c);

    bus.pix_valid   = 1'b0;
    bus.frame_start = 1'b0;
    idle(PIPE + 2, "drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
